// File: rtl/rs_pkg.sv
// Shared constants and default-configuration types for the Tomasulo reservation station.
// rs_entry_t shows the entry layout at default widths; the top re-declares it with its own parameters.
package rs_pkg;
    localparam int ENTRIES_DEF = 8;
    localparam int CDB_N_DEF   = 2;
    localparam int DATA_W_DEF  = 32;
    localparam int ROB_W_DEF   = 4;
    localparam int OP_W_DEF    = 6;
    localparam int PC_W_DEF    = 32;

    // Tag value meaning "operand already present"
    localparam int ROB_NULL = 0;

    typedef struct packed {
        logic                  busy;
        logic [OP_W_DEF-1:0]   op;
        logic [ROB_W_DEF-1:0]  qj;
        logic [DATA_W_DEF-1:0] vj;
        logic [ROB_W_DEF-1:0]  qk;
        logic [DATA_W_DEF-1:0] vk;
        logic [ROB_W_DEF-1:0]  dest;
        logic [PC_W_DEF-1:0]   pc;
    } rs_entry_t;
endpackage

// File: rtl/rs_age_select.sv
// Age matrix tracking allocation order of station entries, plus a one-hot pick of the oldest ready entry.
// Pick is combinational from the registered matrix; matrix updates only when en_in is high.
module rs_age_select
    import rs_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               en_in,
    input  logic               flush_in,
    input  logic [ENTRIES-1:0] busy_in,
    input  logic [ENTRIES-1:0] alloc_in,
    input  logic [ENTRIES-1:0] free_in,
    input  logic [ENTRIES-1:0] ready_in,
    output logic [ENTRIES-1:0] pick_out
);
    // older_q[i][j] set: entry i was allocated before entry j (both still busy)
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;

    always_comb begin
        older_d = older_q;
        if (flush_in) begin
            older_d = '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (free_in[i] || free_in[j]) older_d[i][j] = 1'b0;
                    if (alloc_in[j]) older_d[i][j] = busy_in[i] & ~free_in[i];
                    if (alloc_in[i]) older_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pick_out = ready_in;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (ready_in[j] && older_q[j][i]) pick_out[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            older_q <= '0;
        end else if (en_in) begin
            older_q <= older_d;
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: captures operands from CDB ports, issues oldest ready entry via one output register.
// Dispatch-to-valid is 2 cycles; output holds while valid & !rs_alu_rdy_in; rdy_in low freezes everything.
module reservation_station
    import rs_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int CDB_N   = CDB_N_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  rs_instqueue_rdy_out,
    input  logic                  dispatcher_rs_en_in,
    input  logic [OP_W-1:0]       dispatcher_rs_op_in,
    input  logic [ROB_W-1:0]      dispatcher_rs_qj_in,
    input  logic [ROB_W-1:0]      dispatcher_rs_qk_in,
    input  logic [DATA_W-1:0]     dispatcher_rs_vj_in,
    input  logic [DATA_W-1:0]     dispatcher_rs_vk_in,
    input  logic [ROB_W-1:0]      dispatcher_rs_dest_in,
    input  logic [PC_W-1:0]       dispatcher_rs_pc_in,
    input  logic                  rob_rs_rst_in,
    input  logic [CDB_N-1:0]      cdb_rs_en_in,
    input  logic [CDB_N*ROB_W-1:0]  cdb_rs_b_in,
    input  logic [CDB_N*DATA_W-1:0] cdb_rs_result_in,
    output logic                  rs_alu_valid_out,
    input  logic                  rs_alu_rdy_in,
    output logic [OP_W-1:0]       rs_alu_op_out,
    output logic [DATA_W-1:0]     rs_alu_vj_out,
    output logic [DATA_W-1:0]     rs_alu_vk_out,
    output logic [ROB_W-1:0]      rs_alu_dest_out,
    output logic [PC_W-1:0]       rs_alu_pc_out
);
    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [ROB_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  dest;
        logic [PC_W-1:0]   pc;
    } entry_t;

    typedef struct packed {
        logic              vld;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  dest;
        logic [PC_W-1:0]   pc;
    } out_t;

    entry_t ent_q [ENTRIES];
    entry_t ent_d [ENTRIES];
    out_t   out_q, out_d;

    logic [ENTRIES-1:0] busy, ready, alloc_oh, pick_oh, issue_oh;
    logic               load_out;

    // Returns {tag, value}; lowest matching enabled port wins when several carry the tag
    function automatic logic [ROB_W+DATA_W-1:0] snoop(
        input logic [ROB_W-1:0]        q,
        input logic [DATA_W-1:0]       v,
        input logic [CDB_N-1:0]        en,
        input logic [CDB_N*ROB_W-1:0]  b,
        input logic [CDB_N*DATA_W-1:0] r
    );
        logic [ROB_W+DATA_W-1:0] res;
        res = {q, v};
        for (int p = CDB_N-1; p >= 0; p--) begin
            if (q != ROB_W'(ROB_NULL) && en[p] && b[p*ROB_W +: ROB_W] == q)
                res = {ROB_W'(ROB_NULL), r[p*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && ent_q[i].qj == ROB_W'(ROB_NULL)
                                     && ent_q[i].qk == ROB_W'(ROB_NULL);
        end
    end

    always_comb begin
        alloc_oh = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
        if (!dispatcher_rs_en_in || rob_rs_rst_in) alloc_oh = '0;
    end

    assign rs_instqueue_rdy_out = ~&busy;
    assign load_out = ~out_q.vld | rs_alu_rdy_in;
    assign issue_oh = load_out ? pick_oh : '0;

    rs_age_select #(.ENTRIES(ENTRIES)) u_age (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_in    (rdy_in),
        .flush_in (rob_rs_rst_in),
        .busy_in  (busy),
        .alloc_in (alloc_oh),
        .free_in  (issue_oh),
        .ready_in (ready),
        .pick_out (pick_oh)
    );

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (rob_rs_rst_in) begin
                ent_d[i].busy = 1'b0;
            end else begin
                if (ent_q[i].busy) begin
                    {ent_d[i].qj, ent_d[i].vj} = snoop(ent_q[i].qj, ent_q[i].vj,
                                                       cdb_rs_en_in, cdb_rs_b_in, cdb_rs_result_in);
                    {ent_d[i].qk, ent_d[i].vk} = snoop(ent_q[i].qk, ent_q[i].vk,
                                                       cdb_rs_en_in, cdb_rs_b_in, cdb_rs_result_in);
                end
                if (issue_oh[i]) ent_d[i].busy = 1'b0;
                if (alloc_oh[i]) begin
                    ent_d[i].busy = 1'b1;
                    ent_d[i].op   = dispatcher_rs_op_in;
                    ent_d[i].dest = dispatcher_rs_dest_in;
                    ent_d[i].pc   = dispatcher_rs_pc_in;
                    {ent_d[i].qj, ent_d[i].vj} = snoop(dispatcher_rs_qj_in, dispatcher_rs_vj_in,
                                                       cdb_rs_en_in, cdb_rs_b_in, cdb_rs_result_in);
                    {ent_d[i].qk, ent_d[i].vk} = snoop(dispatcher_rs_qk_in, dispatcher_rs_vk_in,
                                                       cdb_rs_en_in, cdb_rs_b_in, cdb_rs_result_in);
                end
            end
        end
    end

    // Payload is kept when nothing is picked so the output only changes on a real issue
    always_comb begin
        out_d = out_q;
        if (rob_rs_rst_in) begin
            out_d.vld = 1'b0;
        end else if (load_out) begin
            out_d.vld = |pick_oh;
            for (int i = 0; i < ENTRIES; i++) begin
                if (pick_oh[i]) begin
                    out_d.op   = ent_q[i].op;
                    out_d.vj   = ent_q[i].vj;
                    out_d.vk   = ent_q[i].vk;
                    out_d.dest = ent_q[i].dest;
                    out_d.pc   = ent_q[i].pc;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            out_q <= '0;
        end else if (rdy_in) begin
            ent_q <= ent_d;
            out_q <= out_d;
        end
    end

    assign rs_alu_valid_out = out_q.vld;
    assign rs_alu_op_out    = out_q.op;
    assign rs_alu_vj_out    = out_q.vj;
    assign rs_alu_vk_out    = out_q.vk;
    assign rs_alu_dest_out  = out_q.dest;
    assign rs_alu_pc_out    = out_q.pc;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_rs_rst_in, rs_alu_rdy_in;
    logic        dispatcher_rs_en_in;
    logic [5:0]  dispatcher_rs_op_in;
    logic [3:0]  dispatcher_rs_qj_in, dispatcher_rs_qk_in, dispatcher_rs_dest_in;
    logic [31:0] dispatcher_rs_vj_in, dispatcher_rs_vk_in, dispatcher_rs_pc_in;
    logic [1:0]  cdb_rs_en_in;
    logic [7:0]  cdb_rs_b_in;
    logic [63:0] cdb_rs_result_in;
    logic        rs_instqueue_rdy_out, rs_alu_valid_out;
    logic [5:0]  rs_alu_op_out;
    logic [31:0] rs_alu_vj_out, rs_alu_vk_out, rs_alu_pc_out;
    logic [3:0]  rs_alu_dest_out;

    int n_chk  = 0;
    int n_pass = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rs_instqueue_rdy_out(rs_instqueue_rdy_out),
        .dispatcher_rs_en_in(dispatcher_rs_en_in), .dispatcher_rs_op_in(dispatcher_rs_op_in),
        .dispatcher_rs_qj_in(dispatcher_rs_qj_in), .dispatcher_rs_qk_in(dispatcher_rs_qk_in),
        .dispatcher_rs_vj_in(dispatcher_rs_vj_in), .dispatcher_rs_vk_in(dispatcher_rs_vk_in),
        .dispatcher_rs_dest_in(dispatcher_rs_dest_in), .dispatcher_rs_pc_in(dispatcher_rs_pc_in),
        .rob_rs_rst_in(rob_rs_rst_in), .cdb_rs_en_in(cdb_rs_en_in), .cdb_rs_b_in(cdb_rs_b_in),
        .cdb_rs_result_in(cdb_rs_result_in), .rs_alu_valid_out(rs_alu_valid_out),
        .rs_alu_rdy_in(rs_alu_rdy_in), .rs_alu_op_out(rs_alu_op_out), .rs_alu_vj_out(rs_alu_vj_out),
        .rs_alu_vk_out(rs_alu_vk_out), .rs_alu_dest_out(rs_alu_dest_out), .rs_alu_pc_out(rs_alu_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        en;
        logic [5:0]  op;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [3:0]  dest;
        logic [1:0]  cdb_en;
        logic [7:0]  cdb_b;
        logic [63:0] cdb_r;
        logic        e_vld;
        logic [5:0]  e_op;
        logic [31:0] e_vj;
        logic [31:0] e_vk;
        logic [3:0]  e_dest;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic [5:0] op, input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] dest,
                       input logic [1:0] cen, input logic [7:0] cb, input logic [63:0] cr,
                       input logic ev, input logic [5:0] eop, input logic [31:0] evj,
                       input logic [31:0] evk, input logic [3:0] edest);
        vec_t v;
        v.en = en; v.op = op; v.qj = qj; v.vj = vj; v.qk = qk; v.vk = vk; v.dest = dest;
        v.cdb_en = cen; v.cdb_b = cb; v.cdb_r = cr;
        v.e_vld = ev; v.e_op = eop; v.e_vj = evj; v.e_vk = evk; v.e_dest = edest;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        dispatcher_rs_en_in = 1'b0; dispatcher_rs_op_in = '0;
        dispatcher_rs_qj_in = '0; dispatcher_rs_qk_in = '0;
        dispatcher_rs_vj_in = '0; dispatcher_rs_vk_in = '0;
        dispatcher_rs_dest_in = '0; dispatcher_rs_pc_in = '0;
        cdb_rs_en_in = '0; cdb_rs_b_in = '0; cdb_rs_result_in = '0;
        rob_rs_rst_in = 1'b0;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] dest);
        dispatcher_rs_en_in = 1'b1; dispatcher_rs_op_in = op;
        dispatcher_rs_qj_in = qj; dispatcher_rs_vj_in = vj;
        dispatcher_rs_qk_in = qk; dispatcher_rs_vk_in = vk;
        dispatcher_rs_dest_in = dest; dispatcher_rs_pc_in = {28'h0, dest};
    endtask

    task automatic next_cycle();
        @(posedge clk_in); #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rs_alu_rdy_in = 1'b1;
        idle_inputs();

        // basic issue
        add(1, 3, 0, 5, 0, 7, 2, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          1, 3, 5, 7, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        // wakeup via port 1; disabled port 0 carries the same tag and must be ignored
        add(1, 4, 4, 0, 0, 'h11, 3, 0, 0, 0,                       0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2'b10, 8'h44, {32'hAA, 32'hBB},   0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          1, 4, 'hAA, 'h11, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        // dispatch-cycle bypass on port 0
        add(1, 5, 0, 1, 6, 'hDEAD, 5, 2'b01, 8'h06, {32'h0, 32'h9}, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          1, 5, 1, 9, 5);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        // both ports carry the same tag: port 0 wins
        add(1, 6, 7, 'hBEEF, 0, 2, 6, 0, 0, 0,                     0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2'b11, 8'h77, {32'h22, 32'h21},   0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          1, 6, 'h21, 2, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0);

        @(negedge clk_in);
        check("rst_valid", rs_alu_valid_out, 0);
        check("rst_iq_rdy", rs_instqueue_rdy_out, 1);
        check("rst_dest", rs_alu_dest_out, 0);
        check("rst_vj", rs_alu_vj_out, 0);
        next_cycle();
        rst_in = 1'b0;

        foreach (vq[r]) begin
            dispatcher_rs_en_in = vq[r].en; dispatcher_rs_op_in = vq[r].op;
            dispatcher_rs_qj_in = vq[r].qj; dispatcher_rs_vj_in = vq[r].vj;
            dispatcher_rs_qk_in = vq[r].qk; dispatcher_rs_vk_in = vq[r].vk;
            dispatcher_rs_dest_in = vq[r].dest; dispatcher_rs_pc_in = 32'h100;
            cdb_rs_en_in = vq[r].cdb_en; cdb_rs_b_in = vq[r].cdb_b; cdb_rs_result_in = vq[r].cdb_r;
            @(negedge clk_in);
            check($sformatf("row%0d_valid", r), rs_alu_valid_out, vq[r].e_vld);
            check($sformatf("row%0d_iq_rdy", r), rs_instqueue_rdy_out, 1);
            if (vq[r].e_vld) begin
                check($sformatf("row%0d_op", r), rs_alu_op_out, vq[r].e_op);
                check($sformatf("row%0d_vj", r), rs_alu_vj_out, vq[r].e_vj);
                check($sformatf("row%0d_vk", r), rs_alu_vk_out, vq[r].e_vk);
                check($sformatf("row%0d_dest", r), rs_alu_dest_out, vq[r].e_dest);
            end
            next_cycle();
        end

        // fill all eight entries waiting on tag 1
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            dispatch(6'(i), 4'd1, 32'h0, 4'd0, 32'(100 + i), 4'(8 + i));
            @(negedge clk_in);
            if (i == 7) check("iq_rdy_seven_busy", rs_instqueue_rdy_out, 1);
            next_cycle();
        end
        idle_inputs();
        rs_alu_rdy_in = 1'b0;
        cdb_rs_en_in = 2'b01; cdb_rs_b_in = 8'h01; cdb_rs_result_in = 64'h55;
        @(negedge clk_in);
        check("iq_rdy_full", rs_instqueue_rdy_out, 0);
        check("full_valid", rs_alu_valid_out, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk_in);
        check("wake_valid_early", rs_alu_valid_out, 0);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            check($sformatf("hold%0d_valid", c), rs_alu_valid_out, 1);
            check($sformatf("hold%0d_dest", c), rs_alu_dest_out, 8);
            check($sformatf("hold%0d_vj", c), rs_alu_vj_out, 'h55);
            if (c == 0) check("iq_rdy_after_issue", rs_instqueue_rdy_out, 1);
            next_cycle();
        end
        rs_alu_rdy_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            check($sformatf("order%0d_valid", k), rs_alu_valid_out, 1);
            check($sformatf("order%0d_dest", k), rs_alu_dest_out, 8 + k);
            check($sformatf("order%0d_vk", k), rs_alu_vk_out, 100 + k);
            next_cycle();
        end
        @(negedge clk_in);
        check("drain_valid", rs_alu_valid_out, 0);
        next_cycle();

        // flush with one entry on the output and five busy
        rs_alu_rdy_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dispatch(6'd1, 4'd0, 32'(i), 4'd0, 32'd0, 4'(i + 1));
            next_cycle();
        end
        idle_inputs();
        rob_rs_rst_in = 1'b1;
        @(negedge clk_in);
        check("preflush_valid", rs_alu_valid_out, 1);
        check("preflush_dest", rs_alu_dest_out, 1);
        next_cycle();
        rob_rs_rst_in = 1'b0;
        rs_alu_rdy_in = 1'b1;
        @(negedge clk_in);
        check("flush_valid", rs_alu_valid_out, 0);
        check("flush_iq_rdy", rs_instqueue_rdy_out, 1);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            check($sformatf("postflush%0d_valid", c), rs_alu_valid_out, 0);
            next_cycle();
        end

        // stall: broadcast and dispatch while rdy_in is low must be lost
        dispatch(6'd2, 4'd9, 32'h0, 4'd0, 32'd3, 4'd4);
        next_cycle();
        idle_inputs();
        rdy_in = 1'b0;
        dispatch(6'd7, 4'd0, 32'h1, 4'd0, 32'h1, 4'd12);
        cdb_rs_en_in = 2'b01; cdb_rs_b_in = 8'h09; cdb_rs_result_in = 64'h77;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            check($sformatf("stall%0d_valid", c), rs_alu_valid_out, 0);
            next_cycle();
        end
        idle_inputs();
        rdy_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            check($sformatf("unstall%0d_valid", c), rs_alu_valid_out, 0);
            next_cycle();
        end
        cdb_rs_en_in = 2'b10; cdb_rs_b_in = 8'h90; cdb_rs_result_in = {32'h78, 32'h0};
        @(negedge clk_in);
        check("late_wake0_valid", rs_alu_valid_out, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk_in);
        check("late_wake1_valid", rs_alu_valid_out, 0);
        next_cycle();
        @(negedge clk_in);
        check("late_wake_valid", rs_alu_valid_out, 1);
        check("late_wake_vj", rs_alu_vj_out, 'h78);
        check("late_wake_dest", rs_alu_dest_out, 4);
        next_cycle();
        @(negedge clk_in);
        check("late_wake_drain", rs_alu_valid_out, 0);
        next_cycle();

        // asynchronous reset between edges discards a pending entry
        dispatch(6'd3, 4'd0, 32'h5, 4'd0, 32'h6, 4'd7);
        next_cycle();
        idle_inputs();
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_valid", rs_alu_valid_out, 0);
        next_cycle();
        rst_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            check($sformatf("after_rst%0d_valid", c), rs_alu_valid_out, 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
